// File: rtl/cmd_seq_pkg.sv
// Shared types for the command sequencer.
// Ports: none (package only).
// Holds the FSM state encoding, the error code encoding and the calibrate acknowledge byte.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_CHECK,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TO_SENT  = 2'd2,
    ERR_TO_RESP  = 2'd3
  } err_t;

  // Standard acknowledge returned by a remote node after a calibrate command.
  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_seq_mem.sv
// Purpose: DEPTH-entry command/expected-response list, appended in order and read at random.
// Latency: write takes effect on the next clock; read port is combinational.
// Backpressure: writes while full are dropped; full_o flags the condition.
// Ports: clk/rst (sync, active high, empties the list); wr_en_i/wr_cmd_i/wr_exp_i append one entry;
//        rd_idx_i selects the entry shown on rd_cmd_o/rd_exp_o; count_o is the number of entries held;
//        full_o is high when count_o == DEPTH.
module cmd_seq_mem
  import cmd_seq_pkg::*;
#(
  parameter int CMD_W  = 16,
  parameter int RESP_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [CMD_W-1:0]           wr_cmd_i,
  input  logic [RESP_W-1:0]          wr_exp_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [CMD_W-1:0]           rd_cmd_o,
  output logic [RESP_W-1:0]          rd_exp_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CMD_W-1:0]  cmd_mem_q [DEPTH];
  logic [RESP_W-1:0] exp_mem_q [DEPTH];
  logic [AW:0]       count_q;
  logic              wr_acc;

  assign full_o = (count_q == FULL_CNT);
  assign wr_acc = wr_en_i && !full_o;

  // Only the count is reset; stale array contents are never read past count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_acc) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      cmd_mem_q[count_q[AW-1:0]] <= wr_cmd_i;
      exp_mem_q[count_q[AW-1:0]] <= wr_exp_i;
    end
  end

  assign rd_cmd_o = cmd_mem_q[rd_idx_i];
  assign rd_exp_o = exp_mem_q[rd_idx_i];
  assign count_o  = count_q;

endmodule

// File: rtl/cmd_seq_driver.sv
// Purpose: replays the queued command list into a RemoteComm-style port and checks each response byte.
// Latency: start to first send_cmd 2 cycles; CHECK to next send_cmd 1 cycle; phase timeout of timeout_cycles.
// Backpressure: waits on cmd_sent then resp_rdy per entry; load/start ignored unless IDLE (load also when full).
// Ports: clk/rst (sync, active high); load/load_cmd/load_exp append an entry, full flags DEPTH entries;
//        start/timeout_cycles begin a run; cmd/send_cmd drive RemoteComm, cmd_sent/resp_rdy/resp come back;
//        busy/done/pass/err_code/err_idx/num_done report run progress and outcome.
module cmd_seq_driver
  import cmd_seq_pkg::*;
#(
  parameter int CMD_W  = 16,
  parameter int RESP_W = 8,
  parameter int DEPTH  = 8,
  parameter int TO_W   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [CMD_W-1:0]           load_cmd,
  input  logic [RESP_W-1:0]          load_exp,
  output logic                       full,
  input  logic                       start,
  input  logic [TO_W-1:0]            timeout_cycles,
  output logic [CMD_W-1:0]           cmd,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [RESP_W-1:0]          resp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH)-1:0]   err_idx,
  output logic [$clog2(DEPTH):0]     num_done
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic              start_q;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       num_done_q, num_done_d;
  err_t              err_q, err_d;
  logic [AW-1:0]     err_idx_q, err_idx_d;
  logic              pass_q, pass_d;
  logic [TO_W-1:0]   to_q;
  logic [TO_W-1:0]   timer_q, timer_d, timer_inc;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;

  logic [CMD_W-1:0]  rd_cmd;
  logic [RESP_W-1:0] rd_exp;
  logic [AW:0]       count;
  logic              idle, start_acc, to_hit, last;

  assign idle      = (state_q == S_IDLE);
  // start is captured in a register and acted on the following cycle; a second
  // start while the first is pending is dropped.
  assign start_acc = start && idle && !start_q;

  cmd_seq_mem #(
    .CMD_W  (CMD_W),
    .RESP_W (RESP_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (load && idle && !start_q),
    .wr_cmd_i (load_cmd),
    .wr_exp_i (load_exp),
    .rd_idx_i (idx_q),
    .rd_cmd_o (rd_cmd),
    .rd_exp_o (rd_exp),
    .count_o  (count),
    .full_o   (full)
  );

  // Timeout of zero disables the check; the timer saturates so a long wait never wraps.
  assign to_hit    = (to_q != '0) && (timer_q == to_q - 1'b1);
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign last      = ({1'b0, idx_q} == (count - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      idx_q      <= '0;
      num_done_q <= '0;
      err_q      <= ERR_NONE;
      err_idx_q  <= '0;
      pass_q     <= 1'b0;
      to_q       <= '0;
      timer_q    <= '0;
      resp_q     <= '0;
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_acc;
      idx_q      <= idx_d;
      num_done_q <= num_done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      pass_q     <= pass_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      cmd_q      <= cmd_d;
      if (start_acc) begin
        to_q <= timeout_cycles;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    num_done_d = num_done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    pass_d     = pass_q;
    timer_d    = timer_q;
    resp_d     = resp_q;
    cmd_d      = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          num_done_d = '0;
          err_d      = ERR_NONE;
          idx_d      = '0;
          if (count == '0) begin
            pass_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            pass_d  = 1'b0;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        // Keep the command on the bus after the strobe.
        cmd_d   = rd_cmd;
        timer_d = '0;
        state_d = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (cmd_sent && resp_rdy) begin
          resp_d  = resp;
          state_d = S_CHECK;
        end else if (cmd_sent) begin
          timer_d = '0;
          state_d = S_WAIT_RESP;
        end else if (to_hit) begin
          err_d     = ERR_TO_SENT;
          err_idx_d = idx_q;
          state_d   = S_FINISH;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_RESP: begin
        // A response on the timeout cycle still counts.
        if (resp_rdy) begin
          resp_d  = resp;
          state_d = S_CHECK;
        end else if (to_hit) begin
          err_d     = ERR_TO_RESP;
          err_idx_d = idx_q;
          state_d   = S_FINISH;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_CHECK: begin
        if (resp_q == rd_exp) begin
          num_done_d = num_done_q + 1'b1;
          if (last) begin
            pass_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end
        end else begin
          err_d     = ERR_MISMATCH;
          err_idx_d = idx_q;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The strobe cycle shows the entry straight from the list; afterwards the held copy.
  assign cmd      = (state_q == S_SEND) ? rd_cmd : cmd_q;
  assign send_cmd = (state_q == S_SEND);
  assign done     = (state_q == S_FINISH);
  assign busy     = (state_q == S_SEND) || (state_q == S_WAIT_SENT) ||
                    (state_q == S_WAIT_RESP) || (state_q == S_CHECK);
  assign pass     = pass_q;
  assign err_code = err_q;
  assign err_idx  = err_idx_q;
  assign num_done = num_done_q;

endmodule

// File: tb/tb_cmd_seq_driver.sv
// Directed bench for cmd_seq_driver: each task drives one scenario and checks inline.
// Timing reference: "N<k>" is the k-th falling edge after start is driven (start driven at N0).
module tb_cmd_seq_driver;
  import cmd_seq_pkg::*;

  localparam int CMD_W  = 16;
  localparam int RESP_W = 8;
  localparam int DEPTH  = 8;
  localparam int TO_W   = 24;

  logic              clk = 1'b0;
  logic              rst, load, start, cmd_sent, resp_rdy;
  logic [CMD_W-1:0]  load_cmd;
  logic [RESP_W-1:0] load_exp, resp;
  logic [TO_W-1:0]   timeout_cycles;
  logic              full, send_cmd, busy, done, pass;
  logic [CMD_W-1:0]  cmd;
  logic [1:0]        err_code;
  logic [2:0]        err_idx;
  logic [3:0]        num_done;

  int checks = 0;
  int errors = 0;

  // Results captured by run_seq.
  logic [7:0]  rsp_tab [0:15];
  logic [15:0] sent_cmd [0:15];
  int          send_cyc [0:15];
  int          n_sends, done_cyc;
  logic        done_seen, r_pass, r_busy;
  logic [1:0]  r_err;
  logic [2:0]  r_eidx;
  logic [3:0]  r_ndone;
  logic [15:0] r_cmd;

  cmd_seq_driver #(.CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_cmd(load_cmd), .load_exp(load_exp), .full(full),
    .start(start), .timeout_cycles(timeout_cycles), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .err_code(err_code), .err_idx(err_idx), .num_done(num_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
    load_cmd = '0; load_exp = '0; timeout_cycles = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic load_entry(input logic [15:0] c, input logic [7:0] e);
    load = 1'b1; load_cmd = c; load_exp = e;
    step();
    load = 1'b0;
  endtask

  // Starts a run and plays the remote side: cmd_sent s_dly cycles after each strobe
  // (never if negative), resp_rdy r_dly cycles after cmd_sent (same cycle if 0, never if negative).
  task automatic run_seq(input int s_dly, input int r_dly, input logic [23:0] to,
                         input bit inject_load, input int max_cyc);
    int sc, rc, cyc;
    timeout_cycles = to;
    start = 1'b1; n_sends = 0; done_seen = 1'b0; done_cyc = -1; sc = 0; rc = 0;
    step();
    start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < max_cyc) begin
      cmd_sent = 1'b0; resp_rdy = 1'b0; load = 1'b0;
      if (inject_load && cyc == 6) begin
        load = 1'b1; load_cmd = 16'hDEAD; load_exp = 8'h00;
      end
      if (done) begin
        done_seen = 1'b1; done_cyc = cyc; r_pass = pass; r_busy = busy;
        r_err = err_code; r_eidx = err_idx; r_ndone = num_done; r_cmd = cmd;
      end else begin
        if (send_cmd) begin
          if (n_sends < 16) begin
            sent_cmd[n_sends] = cmd;
            send_cyc[n_sends] = cyc;
          end
          n_sends++;
          sc = (s_dly > 0) ? s_dly : 0;
        end else if (sc > 0) begin
          sc--;
          if (sc == 0) begin
            cmd_sent = 1'b1;
            if (r_dly == 0) begin
              resp_rdy = 1'b1; resp = rsp_tab[n_sends-1];
            end else begin
              rc = r_dly;
            end
          end
        end else if (rc > 0) begin
          rc--;
          if (rc == 0) begin
            resp_rdy = 1'b1; resp = rsp_tab[n_sends-1];
          end
        end
        step();
        cyc++;
      end
    end
    load = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd !== 16'h0)     begin errors++; $display("FAIL rst_cmd got %0h want 0", cmd); end
    checks++; if (send_cmd !== 1'b0) begin errors++; $display("FAIL rst_send got %0b want 0", send_cmd); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_done got %0b want 0", done); end
    checks++; if (pass !== 1'b0)     begin errors++; $display("FAIL rst_pass got %0b want 0", pass); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_err got %0d want 0", err_code); end
    checks++; if (err_idx !== 3'd0)  begin errors++; $display("FAIL rst_eidx got %0d want 0", err_idx); end
    checks++; if (num_done !== 4'd0) begin errors++; $display("FAIL rst_ndone got %0d want 0", num_done); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full got %0b want 0", full); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_cmds [0:2];
    exp_cmds[0] = 16'h2000; exp_cmds[1] = 16'h4001; exp_cmds[2] = 16'h5002;
    do_reset();
    for (int i = 0; i < 3; i++) load_entry(exp_cmds[i], POS_ACK);
    run_seq(1, 50, 24'd1000, 1'b0, 2000);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL basic_done got %0b want 1", done_seen); end
    checks++; if (n_sends != 3) begin errors++; $display("FAIL basic_sends got %0d want 3", n_sends); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sent_cmd[i] !== exp_cmds[i]) begin errors++; $display("FAIL basic_cmd%0d got %0h want %0h", i, sent_cmd[i], exp_cmds[i]); end
    end
    // start at N0, strobe at N2; entry gap = 1 (sent) + 50 (resp) + CHECK + SEND = 53.
    checks++; if (send_cyc[0] != 2)  begin errors++; $display("FAIL basic_start_lat got %0d want 2", send_cyc[0]); end
    checks++; if (send_cyc[1] - send_cyc[0] != 53) begin errors++; $display("FAIL basic_gap got %0d want 53", send_cyc[1] - send_cyc[0]); end
    // last strobe N108, resp N159, CHECK N160, FINISH N161.
    checks++; if (done_cyc != 161)   begin errors++; $display("FAIL basic_done_cyc got %0d want 161", done_cyc); end
    checks++; if (r_pass !== 1'b1)   begin errors++; $display("FAIL basic_pass got %0b want 1", r_pass); end
    checks++; if (r_err !== 2'd0)    begin errors++; $display("FAIL basic_err got %0d want 0", r_err); end
    checks++; if (r_ndone !== 4'd3)  begin errors++; $display("FAIL basic_ndone got %0d want 3", r_ndone); end
    checks++; if (r_busy !== 1'b0)   begin errors++; $display("FAIL basic_busy_at_done got %0b want 0", r_busy); end
    checks++; if (r_cmd !== 16'h5002) begin errors++; $display("FAIL basic_cmd_hold got %0h want 5002", r_cmd); end
    step();
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL basic_done_width got %0b want 0", done); end
    checks++; if (pass !== 1'b1)     begin errors++; $display("FAIL basic_pass_sticky got %0b want 1", pass); end
  endtask

  task automatic test_mismatch();
    do_reset();
    load_entry(16'h1111, POS_ACK);
    load_entry(16'h2222, POS_ACK);
    rsp_tab[1] = 8'h5A;
    run_seq(1, 1, 24'd1000, 1'b0, 500);
    rsp_tab[1] = POS_ACK;
    checks++; if (n_sends != 2)      begin errors++; $display("FAIL mis_sends got %0d want 2", n_sends); end
    checks++; if (done_cyc != 10)    begin errors++; $display("FAIL mis_done_cyc got %0d want 10", done_cyc); end
    checks++; if (r_pass !== 1'b0)   begin errors++; $display("FAIL mis_pass got %0b want 0", r_pass); end
    checks++; if (r_err !== 2'd1)    begin errors++; $display("FAIL mis_err got %0d want 1", r_err); end
    checks++; if (r_eidx !== 3'd1)   begin errors++; $display("FAIL mis_eidx got %0d want 1", r_eidx); end
    checks++; if (r_ndone !== 4'd1)  begin errors++; $display("FAIL mis_ndone got %0d want 1", r_ndone); end
  endtask

  task automatic test_timeout();
    do_reset();
    load_entry(16'h7000, POS_ACK);
    // WAIT_SENT entered N3; 100 cycles later FINISH at N103.
    run_seq(-1, -1, 24'd100, 1'b0, 500);
    checks++; if (done_cyc != 103)   begin errors++; $display("FAIL to_sent_cyc got %0d want 103", done_cyc); end
    checks++; if (r_err !== 2'd2)    begin errors++; $display("FAIL to_sent_err got %0d want 2", r_err); end
    checks++; if (r_eidx !== 3'd0)   begin errors++; $display("FAIL to_sent_eidx got %0d want 0", r_eidx); end
    checks++; if (r_pass !== 1'b0)   begin errors++; $display("FAIL to_sent_pass got %0b want 0", r_pass); end
    step();
    // WAIT_RESP entered N4; FINISH at N104.
    run_seq(1, -1, 24'd100, 1'b0, 500);
    checks++; if (done_cyc != 104)   begin errors++; $display("FAIL to_resp_cyc got %0d want 104", done_cyc); end
    checks++; if (r_err !== 2'd3)    begin errors++; $display("FAIL to_resp_err got %0d want 3", r_err); end
    step();
    // Response lands on the last allowed cycle (N103): accepted, FINISH at N105.
    run_seq(1, 100, 24'd100, 1'b0, 500);
    checks++; if (r_err !== 2'd0)    begin errors++; $display("FAIL to_edge_err got %0d want 0", r_err); end
    checks++; if (r_pass !== 1'b1)   begin errors++; $display("FAIL to_edge_pass got %0b want 1", r_pass); end
    checks++; if (done_cyc != 105)   begin errors++; $display("FAIL to_edge_cyc got %0d want 105", done_cyc); end
    step();
    // Zero timeout waits indefinitely.
    run_seq(-1, -1, 24'd0, 1'b0, 400);
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL to_off_done got %0b want 0", done_seen); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL to_off_busy got %0b want 1", busy); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_entry(16'h3000 + 16'(i), POS_ACK);
      if (i == DEPTH - 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early got %0b want 0", full); end
      end
      if (i == DEPTH - 1) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got %0b want 1", full); end
      end
    end
    for (int r = 0; r < 2; r++) begin
      run_seq(1, 1, 24'd1000, 1'b0, 500);
      checks++; if (n_sends != DEPTH) begin errors++; $display("FAIL full_sends_run%0d got %0d want %0d", r, n_sends, DEPTH); end
      checks++; if (r_ndone !== 4'd8) begin errors++; $display("FAIL full_ndone_run%0d got %0d want 8", r, r_ndone); end
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (sent_cmd[i] !== 16'h3000 + 16'(i)) begin errors++; $display("FAIL full_cmd%0d_run%0d got %0h want %0h", i, r, sent_cmd[i], 16'h3000 + 16'(i)); end
      end
      step();
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    do_reset();
    load_entry(16'h1A00, POS_ACK);
    load_entry(16'h1A01, POS_ACK);
    timeout_cycles = '0;
    start = 1'b1; step(); start = 1'b0;    // N1
    step();                                // N2: SEND entry 0
    checks++; if (send_cmd !== 1'b1 || cmd !== 16'h1A00) begin errors++; $display("FAIL abort_send0 got %0b/%0h want 1/1a00", send_cmd, cmd); end
    step(); cmd_sent = 1'b1;               // N3: WAIT_SENT
    step(); cmd_sent = 1'b0; resp_rdy = 1'b1; resp = POS_ACK;   // N4: WAIT_RESP
    step(); resp_rdy = 1'b0;               // N5: CHECK
    step();                                // N6: SEND entry 1
    checks++; if (send_cmd !== 1'b1 || cmd !== 16'h1A01) begin errors++; $display("FAIL abort_send1 got %0b/%0h want 1/1a01", send_cmd, cmd); end
    step(); cmd_sent = 1'b1;               // N7: WAIT_SENT
    step(); cmd_sent = 1'b0;               // N8: WAIT_RESP entry 1
    checks++; if (busy !== 1'b1 || num_done !== 4'd1) begin errors++; $display("FAIL abort_pre got busy %0b ndone %0d want 1/1", busy, num_done); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || send_cmd !== 1'b0) begin errors++; $display("FAIL abort_ctl got %0b%0b%0b want 000", busy, done, send_cmd); end
    checks++; if (cmd !== 16'h0 || num_done !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL abort_vals got %0h/%0d/%0b want 0/0/0", cmd, num_done, full); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin step(); if (done) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
    // Empty list: start at N0, FINISH shown at N2, no strobe.
    start = 1'b1; step(); start = 1'b0;    // N1
    checks++; if (done !== 1'b0 || send_cmd !== 1'b0) begin errors++; $display("FAIL empty_n1 got %0b/%0b want 0/0", done, send_cmd); end
    step();                                // N2
    checks++; if (done !== 1'b1 || pass !== 1'b1 || send_cmd !== 1'b0) begin errors++; $display("FAIL empty_done got %0b/%0b/%0b want 1/1/0", done, pass, send_cmd); end
    checks++; if (num_done !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL empty_vals got %0d/%0b want 0/0", num_done, busy); end
  endtask

  task automatic test_simul_and_busy_load();
    do_reset();
    load_entry(16'h6000, POS_ACK);
    load_entry(16'h6001, POS_ACK);
    // Stray handshakes while idle must not start anything.
    cmd_sent = 1'b1; resp_rdy = 1'b1; step(); cmd_sent = 1'b0; resp_rdy = 1'b0; step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stray_idle got %0b/%0b want 0/0", busy, done); end
    run_seq(1, 0, 24'd1000, 1'b1, 500);
    checks++; if (r_pass !== 1'b1 || r_ndone !== 4'd2) begin errors++; $display("FAIL simul_result got %0b/%0d want 1/2", r_pass, r_ndone); end
    checks++; if (send_cyc[1] - send_cyc[0] != 3) begin errors++; $display("FAIL simul_gap got %0d want 3", send_cyc[1] - send_cyc[0]); end
    step();
    run_seq(1, 1, 24'd1000, 1'b0, 500);
    checks++; if (n_sends != 2 || r_ndone !== 4'd2) begin errors++; $display("FAIL busyload_replay got %0d/%0d want 2/2", n_sends, r_ndone); end
    checks++; if (sent_cmd[1] !== 16'h6001) begin errors++; $display("FAIL busyload_cmd got %0h want 6001", sent_cmd[1]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rsp_tab[i] = POS_ACK;
    test_reset();
    test_basic();
    test_mismatch();
    test_timeout();
    test_full();
    test_reset_abort();
    test_simul_and_busy_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_seq_driver.md
Name: cmd_seq_driver

Overview:
- Parametrised command sequencer that replays a preloaded list of remote commands into a RemoteComm-style interface.
- For each command it pulses send_cmd, waits for cmd_sent and then resp_rdy, checks the response against a per-entry expected byte, and enforces a cycle timeout.
- It sits between a host, bench or self-test controller and RemoteComm, and generalises the one-shot "send calibrate, wait for 0xA5" flow to DEPTH queued commands with per-entry expectations and error reporting.

Parameters:
- CMD_W, 16, command width.
- RESP_W, 8, response width.
- DEPTH, 8, queue entries; a power of 2, at least 2.
- TO_W, 24, timeout counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  push {load_cmd, load_exp} into the queue.
- load_cmd  in  CMD_W  command to queue.
- load_exp  in  RESP_W  expected response for that entry.
- full  out  1  queue holds DEPTH entries.
- start  in  1  begin replaying the queue.
- timeout_cycles  in  TO_W  per-phase timeout limit; sampled at start.
- cmd  out  CMD_W  command to RemoteComm.
- send_cmd  out  1  one-cycle send strobe.
- cmd_sent  in  1  RemoteComm transmit-complete pulse.
- resp_rdy  in  1  RemoteComm response-valid pulse.
- resp  in  RESP_W  response byte.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when the sequence ends.
- pass  out  1  last sequence succeeded; sticky until the next start.
- err_code  out  2  0 NONE, 1 MISMATCH, 2 TIMEOUT_SENT, 3 TIMEOUT_RESP.
- err_idx  out  $clog2(DEPTH)  index of the failing entry.
- num_done  out  $clog2(DEPTH)+1  entries completed successfully.

Behaviour:
- Reset values:
  - Queue emptied; state IDLE.
  - cmd=0, send_cmd=0, busy=0, done=0, pass=0, err_code=0, err_idx=0, num_done=0, full=0.
- Reset mid-sequence aborts the sequence immediately; no done pulse is produced.
- Queue:
  - load is accepted only in IDLE and when not full.
  - load while busy or while full is ignored, with no state change.
  - The queue is not consumed destructively: the read pointer resets to 0 at each start, so the same list can be replayed.
  - A new load after a completed run appends to the existing list.
  - clear-by-reset only.
- State machine, states IDLE, SEND, WAIT_SENT, WAIT_RESP, CHECK, FINISH:
  - IDLE:
    - start with an empty queue goes to FINISH. pass=1, num_done=0.
    - start with a non-empty queue clears num_done, err_code and pass, latches timeout_cycles, sets busy=1, and goes to SEND.
    - start is ignored when not in IDLE.
  - SEND: drive cmd=entry[idx].cmd and pulse send_cmd for exactly 1 cycle, then go to WAIT_SENT with the timer cleared. cmd holds its value until the next SEND.
  - WAIT_SENT:
    - cmd_sent goes to WAIT_RESP with the timer cleared.
    - If cmd_sent and resp_rdy arrive in the same cycle, latch resp and go to CHECK.
    - timer==timeout_cycles-1 goes to FINISH with err_code=2.
  - WAIT_RESP:
    - resp_rdy latches resp and goes to CHECK.
    - timer==timeout_cycles-1 goes to FINISH with err_code=3.
    - A resp_rdy arriving on the timeout cycle wins over the timeout.
  - CHECK:
    - Latched resp == entry[idx].exp: num_done++. If idx==count-1, go to FINISH with pass=1; otherwise idx++ and go to SEND.
    - Mismatch goes to FINISH with err_code=1.
  - FINISH: err_idx=idx on error. done pulses for 1 cycle, busy drops in the same cycle, then go to IDLE.
- Timer:
  - Saturating counter of width TO_W, one per phase.
  - timeout_cycles==0 disables the timeout; the block waits forever.
- Latency: start to first send_cmd is 2 cycles. CHECK to the next send_cmd is 1 cycle.
- Stray cmd_sent/resp_rdy pulses in IDLE, SEND or CHECK are ignored.
- DEPTH entries is legal: count is $clog2(DEPTH)+1 bits wide and full = (count==DEPTH).

Decomposition:
- Package cmd_seq_pkg holds:
  - the state_t enum;
  - the err_t enum {ERR_NONE, ERR_MISMATCH, ERR_TO_SENT, ERR_TO_RESP};
  - localparam POS_ACK = 8'hA5, the standard calibrate acknowledge.
- Sub-module cmd_seq_mem: a DEPTH x (CMD_W+RESP_W) register array with write pointer, count and full, plus a combinational read port addressed by idx.
- FSM and timer live in the top module.

Test Plan:
- Load 3 entries {0x2000/0xA5, 0x4001/0xA5, 0x5002/0xA5}, start, and have the responder ack each after 50 cycles -> exactly 3 send_cmd pulses with cmd in order, done with pass=1, num_done=3, err_code=0.
- Load 2 entries, second exp=0xA5 but the responder returns 0x5A -> done, pass=0, err_code=1, err_idx=1, num_done=1.
- timeout_cycles=100 and cmd_sent never asserted -> done exactly 100 cycles after the WAIT_SENT entry, err_code=2, err_idx=0. Repeat with cmd_sent given but resp_rdy withheld -> err_code=3.
- Load DEPTH+2 entries -> full=1 after DEPTH loads, extra loads ignored. Run -> DEPTH sends, num_done=DEPTH. Start again -> the same DEPTH commands are replayed.
- Assert rst during WAIT_RESP of entry 1 -> next cycle all outputs are at reset values and there is no done pulse. Start with an empty queue -> done after 2 cycles, pass=1, no send_cmd.
- cmd_sent and resp_rdy in the same cycle with resp=0xA5 -> accepted. load pulsed while busy -> ignored, and a post-run replay shows the same count.
